// File: rtl/xor_pkg.sv
// Shared types and helpers for the 4-bit XOR stream path.
// Contents: default nibble width, nibble type, decoder state enum and
// a rotate-left helper for nibble-wide keys.
package xor_pkg;

   localparam int NIBBLE_W = 4;

   typedef logic [NIBBLE_W-1:0] nibble_t;

   typedef enum logic {
      WAIT_KEY = 1'b0,
      RUN      = 1'b1
   } dec_state_t;

   // Rotate a nibble left by n positions (n taken modulo the nibble width).
   function automatic nibble_t rotl_nibble(nibble_t v, int n);
      int k;
      k = ((n % NIBBLE_W) + NIBBLE_W) % NIBBLE_W;
      if (k == 0) begin
         return v;
      end
      return nibble_t'((v << k) | (v >> (NIBBLE_W - k)));
   endfunction

endpackage

// File: rtl/xor_dec_fifo.sv
// Small synchronous FIFO with first-word fall-through head register.
// The head is a register, so it reads 0 after reset and keeps the last
// popped value while the FIFO is empty. Push is ignored when full and
// pop is ignored when empty.
module xor_dec_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       not_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
   localparam logic [LW-1:0] ONE_L   = LW'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW-1:0]    rd_ptr_inc;
   logic [LW-1:0]    count_reg;
   logic [WIDTH-1:0] head_reg;
   logic [WIDTH-1:0] head_next;
   logic             push_do;
   logic             pop_do;

   assign push_do    = push && (count_reg != DEPTH_L);
   assign pop_do     = pop && (count_reg != '0);
   assign rd_ptr_inc = rd_ptr_reg + 1'b1;

   // Storage array: written on push, never reset.
   always_ff @(posedge clk) begin
      if (push_do) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   // Next head: the entry behind the popped one, or the incoming word when
   // it lands in an empty (or emptying) FIFO; otherwise hold.
   always_comb begin
      head_next = head_reg;
      if (pop_do && (count_reg > ONE_L)) begin
         head_next = mem[rd_ptr_inc];
      end else if (push_do && ((count_reg == '0) || (pop_do && (count_reg == ONE_L)))) begin
         head_next = push_data;
      end
   end

   // Pointers, occupancy and head register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         head_reg   <= '0;
      end else begin
         head_reg <= head_next;
         if (push_do) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop_do) begin
            rd_ptr_reg <= rd_ptr_inc;
         end
         case ({push_do, pop_do})
            2'b10:   count_reg <= count_reg + ONE_L;
            2'b01:   count_reg <= count_reg - ONE_L;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign head      = head_reg;
   assign level     = count_reg;
   assign not_empty = (count_reg != '0);

endmodule

// File: rtl/xor_stream_decoder.sv
// XOR stream decoder: recovers plaintext as in_data ^ key with a loadable
// key that rotates left after every accepted nibble, buffering results in
// a small output FIFO.
// Optional build macro XOR_DEC_PARITY_EN adds in_par / sticky par_err.
module xor_stream_decoder
   import xor_pkg::*;
#(
   parameter int WIDTH      = NIBBLE_W,
   parameter int DEPTH      = 2,
   parameter int KEY_ROTATE = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       key_load,
   input  logic [WIDTH-1:0]           key_in,
   input  logic                       in_valid,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       in_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [WIDTH-1:0]           out_inv,
   output logic [WIDTH-1:0]           out_or,
   output logic [$clog2(DEPTH):0]     level,
`ifdef XOR_DEC_PARITY_EN
   input  logic                       in_par,
   output logic                       par_err,
`endif
   output logic [7:0]                 decoded_cnt
);

   localparam int LW = $clog2(DEPTH) + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

   dec_state_t       state_reg;
   logic [WIDTH-1:0] key_reg;
   logic [WIDTH-1:0] key_rot;
   logic [7:0]       cnt_reg;
   logic [LW-1:0]    level_int;
   logic             accept;
   logic             pop;

   // Ready depends only on registered state, never on out_ready.
   assign in_ready = (state_reg == RUN) && (level_int < DEPTH_L);
   assign accept   = in_valid && in_ready;
   assign pop      = out_valid && out_ready;

   // Rotated key: the package helper covers the nibble case, any other
   // width uses a plain concatenation.
   generate
      if (WIDTH == NIBBLE_W) begin : g_rot_nibble
         assign key_rot = rotl_nibble(nibble_t'(key_reg), KEY_ROTATE);
      end else begin : g_rot_generic
         localparam int R = ((KEY_ROTATE % WIDTH) + WIDTH) % WIDTH;
         if (R == 0) begin : g_static
            assign key_rot = key_reg;
         end else begin : g_rotate
            assign key_rot = {key_reg[WIDTH-1-R:0], key_reg[WIDTH-1:WIDTH-R]};
         end
      end
   endgenerate

   // Control FSM, key register and accept counter. A key_load on the same
   // edge as an accept wins over the rotation (push still uses old key).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= WAIT_KEY;
         key_reg   <= '0;
         cnt_reg   <= '0;
      end else begin
         case (state_reg)
            WAIT_KEY: begin
               if (key_load) begin
                  key_reg   <= key_in;
                  state_reg <= RUN;
               end
            end
            RUN: begin
               if (key_load) begin
                  key_reg <= key_in;
               end else if (accept) begin
                  key_reg <= key_rot;
               end
               if (accept) begin
                  cnt_reg <= cnt_reg + 8'd1;
               end
            end
            default: state_reg <= WAIT_KEY;
         endcase
      end
   end

`ifdef XOR_DEC_PARITY_EN
   logic par_err_reg;

   // Sticky parity flag; key_load clears it, but an error on the same
   // edge as the clearing load is still recorded.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         par_err_reg <= 1'b0;
      end else begin
         if (key_load) begin
            par_err_reg <= 1'b0;
         end
         if (accept && ((^in_data) != in_par)) begin
            par_err_reg <= 1'b1;
         end
      end
   end

   assign par_err = par_err_reg;
`endif

   xor_dec_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (accept),
      .push_data (in_data ^ key_reg),
      .pop       (pop),
      .head      (out_data),
      .level     (level_int),
      .not_empty (out_valid)
   );

   assign level       = level_int;
   assign decoded_cnt = cnt_reg;
   assign out_inv     = ~out_data;
   assign out_or      = out_data | out_inv;

endmodule

// File: tb/tb_xor_stream_decoder.sv
// Directed self-checking bench for xor_stream_decoder (WIDTH=4, DEPTH=2,
// KEY_ROTATE=1). Expected values are hand-computed constants.
module tb_xor_stream_decoder;

   logic       clk = 1'b0;
   logic       reset;
   logic       key_load;
   logic [3:0] key_in;
   logic       in_valid;
   logic [3:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic [3:0] out_inv;
   logic [3:0] out_or;
   logic [1:0] level;
   logic [7:0] decoded_cnt;
`ifdef XOR_DEC_PARITY_EN
   logic       in_par;
   logic       par_err;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   xor_stream_decoder #(
      .WIDTH      (4),
      .DEPTH      (2),
      .KEY_ROTATE (1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .key_load    (key_load),
      .key_in      (key_in),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_inv     (out_inv),
      .out_or      (out_or),
      .level       (level),
`ifdef XOR_DEC_PARITY_EN
      .in_par      (in_par),
      .par_err     (par_err),
`endif
      .decoded_cnt (decoded_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check the output side in one go and log the transaction.
   task automatic check_out(input string tag, input logic v, input logic [3:0] d,
                            input logic [1:0] lv, input logic [7:0] cnt);
      $display("[%0t] %s: valid=%0b data=%h level=%0d cnt=%0d ready=%0b",
               $time, tag, out_valid, out_data, level, decoded_cnt, in_ready);
      check({tag, ".valid"}, 32'(out_valid), 32'(v));
      check({tag, ".data"},  32'(out_data),  32'(d));
      check({tag, ".level"}, 32'(level),     32'(lv));
      check({tag, ".cnt"},   32'(decoded_cnt), 32'(cnt));
   endtask

   initial begin
      reset     = 1'b1;
      key_load  = 1'b0;
      key_in    = 4'h0;
      in_valid  = 1'b0;
      in_data   = 4'h0;
      out_ready = 1'b0;
`ifdef XOR_DEC_PARITY_EN
      in_par    = 1'b0;
`endif
      tick();
      tick();

      // Reset state
      check_out("reset", 1'b0, 4'h0, 2'd0, 8'd0);
      check("reset.in_ready", 32'(in_ready), 32'd0);
      reset = 1'b0;

      // 1: no key loaded -> nothing accepted
      in_valid = 1'b1;
      in_data  = 4'h3;
      tick();
      tick();
      check("nokey.in_ready", 32'(in_ready), 32'd0);
      check_out("nokey", 1'b0, 4'h0, 2'd0, 8'd0);

      // 2: key 0110, send 0011 -> 0101
      in_valid = 1'b0;
      key_load = 1'b1;
      key_in   = 4'h6;
      tick();
      key_load = 1'b0;
      check("run.in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = 4'h3;
      tick();
      in_valid = 1'b0;
      check_out("single", 1'b1, 4'h5, 2'd1, 8'd1);
      check("single.inv", 32'(out_inv), 32'hA);
      check("single.or",  32'(out_or),  32'hF);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_out("single_pop", 1'b0, 4'h5, 2'd0, 8'd1);

      // 3: reload key 0110, fill FIFO with out_ready=0
      key_load = 1'b1;
      key_in   = 4'h6;
      tick();
      key_load = 1'b0;
      in_valid = 1'b1;
      in_data  = 4'h3;
      tick();
      check_out("fill1", 1'b1, 4'h5, 2'd1, 8'd2);
      in_data = 4'h9;
      tick();
      check_out("fill2", 1'b1, 4'h5, 2'd2, 8'd3);
      check("full.in_ready", 32'(in_ready), 32'd0);
      in_data = 4'h0;
      tick();
      tick();
      check_out("held", 1'b1, 4'h5, 2'd2, 8'd3);

      // 4: release out_ready while streaming (key is now 1001)
      out_ready = 1'b1;
      tick();
      check_out("drain_full", 1'b1, 4'h5, 2'd1, 8'd3);
      tick();
      check_out("pushpop1", 1'b1, 4'h9, 2'd1, 8'd4);
      in_data = 4'h6;
      tick();
      check_out("pushpop2", 1'b1, 4'h5, 2'd1, 8'd5);
      in_valid = 1'b0;
      tick();
      check_out("drained", 1'b0, 4'h5, 2'd0, 8'd5);

      // 5: key_load (1111) with accept of 1010 under key 0110
      out_ready = 1'b0;
      key_load  = 1'b1;
      key_in    = 4'hF;
      in_valid  = 1'b1;
      in_data   = 4'hA;
      tick();
      key_load = 1'b0;
      check_out("load_accept", 1'b1, 4'hC, 2'd1, 8'd6);
      out_ready = 1'b1;
      in_data   = 4'h0;
      tick();
      check_out("unrotated_key", 1'b1, 4'hF, 2'd1, 8'd7);
      in_valid  = 1'b0;
      out_ready = 1'b0;

      // Asynchronous reset mid-cycle with level=1
      #2;
      reset = 1'b1;
      #1;
      check_out("async_reset", 1'b0, 4'h0, 2'd0, 8'd0);
      check("async_reset.in_ready", 32'(in_ready), 32'd0);
      tick();
      reset    = 1'b0;
      in_valid = 1'b1;
      in_data  = 4'h5;
      tick();
      tick();
      check_out("wait_key_again", 1'b0, 4'h0, 2'd0, 8'd0);

      // decoded_cnt wrap 255 -> 0 with continuous flow
      key_load  = 1'b1;
      key_in    = 4'h0;
      in_valid  = 1'b0;
      tick();
      key_load  = 1'b0;
      in_valid  = 1'b1;
      in_data   = 4'h7;
      out_ready = 1'b1;
      for (int i = 0; i < 255; i++) begin
         tick();
      end
      check("wrap.cnt255", 32'(decoded_cnt), 32'd255);
      tick();
      check("wrap.cnt0", 32'(decoded_cnt), 32'd0);
      in_valid  = 1'b0;
      tick();
      out_ready = 1'b0;

`ifdef XOR_DEC_PARITY_EN
      // 6: parity error is sticky until key_load
      key_load = 1'b1;
      key_in   = 4'h0;
      tick();
      key_load = 1'b0;
      check("par.clear_start", 32'(par_err), 32'd0);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 4'h3;
      in_par    = 1'b0;
      tick();
      check("par.good", 32'(par_err), 32'd0);
      in_data = 4'h7;
      in_par  = 1'b0;
      tick();
      in_valid = 1'b0;
      check("par.bad", 32'(par_err), 32'd1);
      tick();
      tick();
      check("par.sticky", 32'(par_err), 32'd1);
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      check("par.cleared", 32'(par_err), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
